// File: rtl/fb_fill_engine_if.sv
// Avalon-MM write-only bus between the framebuffer fill engine and SDRAM.
// Signals:
//   avm_address     - byte address of the current pixel write
//   avm_write       - write request
//   avm_writedata   - pixel colour, 0xAARRGGBB
//   avm_byteenable  - byte lanes, all four enabled for every write
//   avm_waitrequest - slave stall; the master holds everything while high
// Modports: master (fill engine side), slave (memory side).
interface fb_fill_engine_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] avm_address;
    logic                  avm_write;
    logic [31:0]           avm_writedata;
    logic [3:0]            avm_byteenable;
    logic                  avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_waitrequest
    );
endinterface

// File: rtl/fb_fill_engine.sv
// Framebuffer fill engine. A start pulse latches colour, base address and
// dimensions, then the engine writes the colour to every pixel of the
// width x height framebuffer through an Avalon-MM write master, one pixel
// per cycle when the slave does not stall.
// Ports:
//   clock, reset_n     - system clock, synchronous active-low reset
//   start_i            - one-cycle fill command (ignored unless idle)
//   fb_base_addr_i     - byte address of pixel (0,0), 4-byte aligned
//   fill_color_i       - fill colour 0xAARRGGBB
//   fb_width_i/height_i- framebuffer dimensions in pixels
//   avm                - Avalon-MM write master
//   busy_o             - high while pixel writes are in progress
//   done_o             - one-cycle completion pulse
//   pixels_written_o   - accepted writes since the last accepted start
module fb_fill_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] fb_base_addr_i,
    input  logic [31:0]           fill_color_i,
    input  logic [DIM_WIDTH-1:0]  fb_width_i,
    input  logic [DIM_WIDTH-1:0]  fb_height_i,
    fb_fill_engine_if.master      avm,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           pixels_written_o
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           color_q, color_d;
    logic [DIM_WIDTH-1:0]  width_q, width_d;
    logic [DIM_WIDTH-1:0]  height_q, height_d;
    logic [DIM_WIDTH-1:0]  x_q, x_d;
    logic [DIM_WIDTH-1:0]  y_q, y_d;
    logic [31:0]           pix_q, pix_d;
    logic                  write_q, write_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  accept_s;
    logic                  last_x_s;
    logic                  last_y_s;

    // A write completes on any edge where the request is up and the slave is not stalling.
    assign accept_s = write_q & ~avm.avm_waitrequest;
    assign last_x_s = (x_q == (width_q - DIM_WIDTH'(1)));
    assign last_y_s = (y_q == (height_q - DIM_WIDTH'(1)));

    // Next-state and next-output logic; outputs are computed one cycle ahead so they leave registers.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        color_d  = color_q;
        width_d  = width_q;
        height_d = height_q;
        x_d      = x_q;
        y_d      = y_q;
        pix_d    = pix_q;
        write_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d   = fb_base_addr_i;
                    color_d  = fill_color_i;
                    width_d  = fb_width_i;
                    height_d = fb_height_i;
                    x_d      = DIM_WIDTH'(0);
                    y_d      = DIM_WIDTH'(0);
                    pix_d    = 32'd0;
                    // An empty framebuffer skips the bus entirely.
                    if ((fb_width_i == DIM_WIDTH'(0)) || (fb_height_i == DIM_WIDTH'(0))) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                        write_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                write_d = 1'b1;
                busy_d  = 1'b1;
                if (accept_s) begin
                    // Rows are contiguous, so a running +4 covers the whole frame.
                    addr_d = addr_q + ADDR_WIDTH'(4);
                    pix_d  = pix_q + 32'd1;
                    if (last_x_s) begin
                        x_d = DIM_WIDTH'(0);
                        y_d = y_q + DIM_WIDTH'(1);
                    end else begin
                        x_d = x_q + DIM_WIDTH'(1);
                    end
                    if (last_x_s && last_y_s) begin
                        state_d = ST_DONE;
                        write_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; an in-flight write is simply dropped.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= ADDR_WIDTH'(0);
            color_q  <= 32'd0;
            width_q  <= DIM_WIDTH'(0);
            height_q <= DIM_WIDTH'(0);
            x_q      <= DIM_WIDTH'(0);
            y_q      <= DIM_WIDTH'(0);
            pix_q    <= 32'd0;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            color_q  <= color_d;
            width_q  <= width_d;
            height_q <= height_d;
            x_q      <= x_d;
            y_q      <= y_d;
            pix_q    <= pix_d;
            write_q  <= write_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign avm.avm_address    = addr_q;
    assign avm.avm_write      = write_q;
    assign avm.avm_writedata  = color_q;
    assign avm.avm_byteenable = 4'hF;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign pixels_written_o   = pix_q;
endmodule

// File: tb/tb_fb_fill_engine.sv
// Self-checking bench for fb_fill_engine: expected pixel writes are queued
// when a fill is started and popped as the DUT's writes are accepted.
module tb_fb_fill_engine;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] fb_base_addr = 32'd0;
    logic [31:0] fill_color = 32'd0;
    logic [15:0] fb_width = 16'd0;
    logic [15:0] fb_height = 16'd0;
    logic        busy;
    logic        done;
    logic [31:0] pixels_written;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  done_cnt = 0;

    fb_fill_engine_if #(.ADDR_WIDTH(32)) avm();

    fb_fill_engine #(.ADDR_WIDTH(32), .DIM_WIDTH(16)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start_i          (start),
        .fb_base_addr_i   (fb_base_addr),
        .fill_color_i     (fill_color),
        .fb_width_i       (fb_width),
        .fb_height_i      (fb_height),
        .avm              (avm.master),
        .busy_o           (busy),
        .done_o           (done),
        .pixels_written_o (pixels_written)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Bus monitor: every write cycle must match the head of the scoreboard (this also proves hold during stalls).
    always @(negedge clock) begin
        if (reset_n && avm.avm_write) begin
            if (sb.size() == 0) begin
                check_eq("spurious_write", {31'd0, avm.avm_write}, 32'd0);
            end else begin
                check_eq("wr_addr", avm.avm_address, sb[0].addr);
                check_eq("wr_data", avm.avm_writedata, sb[0].data);
                check_eq("wr_be", {28'd0, avm.avm_byteenable}, 32'h0000000F);
                check_eq("busy_vs_write", {31'd0, busy}, 32'd1);
                if (!avm.avm_waitrequest) void'(sb.pop_front());
            end
        end
        if (reset_n && done) begin
            done_cnt++;
            check_eq("busy_with_done", {31'd0, busy}, 32'd0);
        end
    end

    task automatic run_fill(input logic [31:0] base, input logic [31:0] color,
                            input logic [15:0] w, input logic [15:0] h,
                            input int stalls, input int mid_start, input int rst_at);
        logic [31:0] a;
        int          cnt;
        int          stall_left;
        int          exp_lat;
        int          npix;
        npix = int'(w) * int'(h);
        exp_lat = (npix == 0) ? 1 : npix + stalls + 1;
        a = base;
        for (int i = 0; i < npix; i++) begin
            sb.push_back('{addr: a, data: color});
            a = a + 32'd4;
        end
        done_cnt = 0;
        fb_base_addr = base;
        fill_color = color;
        fb_width = w;
        fb_height = h;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        cnt = 1;
        stall_left = stalls;
        avm.avm_waitrequest = (stall_left > 0);
        if (stall_left > 0) stall_left--;
        while (cnt < 200) begin
            if (done) break;
            if (cnt == rst_at) begin
                reset_n = 1'b0;
                @(posedge clock);
                #1;
                reset_n = 1'b1;
                check_eq("rst_write", {31'd0, avm.avm_write}, 32'd0);
                check_eq("rst_busy", {31'd0, busy}, 32'd0);
                check_eq("rst_done", {31'd0, done}, 32'd0);
                check_eq("rst_pixels", pixels_written, 32'd0);
                check_eq("rst_addr", avm.avm_address, 32'd0);
                sb.delete();
                avm.avm_waitrequest = 1'b0;
                return;
            end
            if (cnt == mid_start) begin
                start = 1'b1;
                fb_base_addr = 32'h0000_8000;
                fill_color = 32'h0BAD_C0DE;
                fb_width = 16'd2;
                fb_height = 16'd2;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            cnt++;
            avm.avm_waitrequest = (stall_left > 0);
            if (stall_left > 0) stall_left--;
        end
        check_eq("done_latency", cnt, exp_lat);
        check_eq("busy_at_done", {31'd0, busy}, 32'd0);
        check_eq("pixels_at_done", pixels_written, npix);
        @(posedge clock);
        #1;
        check_eq("done_one_cycle", {31'd0, done}, 32'd0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check_eq("done_pulses", done_cnt, 32'd1);
        check_eq("sb_drained", sb.size(), 32'd0);
        check_eq("pixels_hold", pixels_written, npix);
    endtask

    initial begin
        avm.avm_waitrequest = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("reset_write", {31'd0, avm.avm_write}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_addr", avm.avm_address, 32'd0);
        check_eq("reset_data", avm.avm_writedata, 32'd0);
        check_eq("reset_pixels", pixels_written, 32'd0);
        check_eq("reset_be", {28'd0, avm.avm_byteenable}, 32'h0000000F);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Basic 4x2 fill, no stalls.
        run_fill(32'h0000_1000, 32'hFF00_FF00, 16'd4, 16'd2, 0, 0, 0);
        // 2x1 with three stall cycles on the first write.
        run_fill(32'h0000_1000, 32'hA1B2_C3D4, 16'd2, 16'd1, 3, 0, 0);
        // Zero width: no bus traffic, immediate done.
        run_fill(32'h0000_3000, 32'h1111_2222, 16'd0, 16'd5, 0, 0, 0);
        // Zero height as well.
        run_fill(32'h0000_3000, 32'h1111_2222, 16'd7, 16'd0, 0, 0, 0);
        // Second start mid-fill with different inputs is ignored.
        run_fill(32'h0000_1000, 32'hFF00_FF00, 16'd4, 16'd2, 0, 3, 0);
        // Reset in cycle 4, then a full fresh fill.
        run_fill(32'h0000_1000, 32'hFF00_FF00, 16'd4, 16'd2, 0, 0, 4);
        @(posedge clock);
        #1;
        run_fill(32'h0000_2000, 32'h1234_5678, 16'd4, 16'd2, 0, 0, 0);
        // Address wraps through zero.
        run_fill(32'hFFFF_FFF8, 32'hCAFE_F00D, 16'd4, 16'd1, 0, 0, 0);
        // Multi-row fill with a stall burst at the start.
        run_fill(32'h0010_0000, 32'h00FF_00FF, 16'd3, 16'd3, 2, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fb_fill_engine.md
# fb_fill_engine

Framebuffer fill engine that sits directly downstream of the GPU register file. On a start pulse it latches fill colour, framebuffer base address, width and height, then writes the colour to every pixel of the width×height framebuffer through an Avalon-MM write master to SDRAM. It reports busy, a one-cycle done pulse and a count of pixels written.

## Interface
- `ADDR_WIDTH`, 32, Avalon master address width (byte addressing).
- `DIM_WIDTH`, 16, width of the width and height inputs.
- `clock`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse from the fill command register write.
- `fb_base_addr`  in  ADDR_WIDTH  byte address of pixel (0,0). Must be 4-byte aligned.
- `fill_color`  in  32  fill colour, 0xAARRGGBB.
- `fb_width`  in  DIM_WIDTH  pixels per row.
- `fb_height`  in  DIM_WIDTH  rows.
- `avm_address`  out  ADDR_WIDTH  write address.
- `avm_write`  out  1  write request.
- `avm_writedata`  out  32  latched colour.
- `avm_byteenable`  out  4  constant 4'hF.
- `avm_waitrequest`  in  1  slave stall.
- `busy`  out  1  high in the WRITE state.
- `done`  out  1  one-cycle completion pulse.
- `pixels_written`  out  32  accepted writes since the last accepted start.

## Operation
- **States:** IDLE, WRITE, DONE.
- **IDLE**
  - `start`=1 latches `fb_base_addr`, `fill_color`, `fb_width` and `fb_height`.
  - The same edge clears `x`, `y` and `pixels_written`, and sets `addr` to the base address.
  - Next state is WRITE, or DONE if width==0 or height==0 (no bus writes in that case).
- **WRITE**
  - `avm_write`=1; `avm_address` = running `addr`.
  - A write is accepted when `avm_write`=1 and `avm_waitrequest`=0.
  - While `avm_waitrequest`=1, address, data and write are held stable (Avalon rule).
  - On each accepted write: `addr` += 4 (wraps modulo 2^ADDR_WIDTH) and `pixels_written` += 1.
  - Counters advance on each accepted write:
    - If `x`==width−1: `x`←0 and `y`←`y`+1.
    - Otherwise `x`←`x`+1.
  - The accept with `x`==width−1 and `y`==height−1 goes to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
- **Address and count rules**
  - Rows are contiguous: stride = width×4 bytes.
  - Address is a running increment; there is no multiplier.
- **start handling**
  - `start` in WRITE or DONE is ignored; no queuing.
  - Inputs changing after latch have no effect.
- **Register values**
  - `pixels_written` holds its value after DONE until the next accepted start.
  - It reaches width×height at completion.
- **Reset** (synchronous; any state, including mid-write)
  - State←IDLE.
  - `avm_write`, `busy`, `done` ← 0.
  - `avm_address`, `avm_writedata`, `pixels_written` ← 0.
  - `avm_byteenable` = 4'hF at all times.
  - A write outstanding at reset is abandoned.

## Timing
- **Start latency:** `start` sampled at edge N → `avm_write`=1 and `busy`=1 during cycle N+1.
- **Throughput:** one pixel per cycle with `avm_waitrequest` low. Each stall cycle adds one cycle.
- **Total cycles:** start→done = W×H + stalls + 1. `done` is asserted the cycle after the last accepted write.
- **busy:** falls in that same cycle; `busy` and `done` are never high together.
- **Zero size:** `start` at N → `done` at N+1, `busy` never high.
- **Next start:** earliest accepted start is the cycle after `done` (IDLE).
- **Registered outputs:** all outputs are registered; none are combinational from `avm_waitrequest`.

## Test plan
- **Basic 4×2 fill:** base 0x1000, colour 0xFF00FF00, `avm_waitrequest`=0.
  - Start at cycle 0 → 8 writes in cycles 1–8 to 0x1000…0x101C, data 0xFF00FF00, byteenable F.
  - `done` at cycle 9; `pixels_written`=8.
- **Waitrequest stalls:** 2×1 fill with waitrequest high for 3 cycles on the first write.
  - Address 0x1000 and data held 4 cycles, then 0x1004.
  - `done` 6 cycles after start.
- **Zero size:** width=0, height=5.
  - No `avm_write`, `done` the cycle after start, `pixels_written`=0.
- **Start while busy:** second start mid-fill with different colour and base.
  - Ignored; original 8 writes complete unchanged, exactly one `done` pulse.
- **Reset mid-fill:** `reset_n` low on cycle 4 of a 4×2 fill.
  - Next cycle: `avm_write`=0, `busy`=0, `pixels_written`=0, state IDLE.
  - A new start then runs a full fill.
- **Address wrap:** base 0xFFFFFFF8, 4×1 fill.
  - Addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004; `done`; `pixels_written`=4.
